// File: rtl/sum_pkg.sv
// Shared definitions for the word-serial adder sequencer.
//   sum_state_e : controller FSM states
//   DefaultN/W  : default operand and slice widths
//   PropBit     : fill bit for slice operand b on non-accepted cycles
package sum_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClr,
    StRun,
    StDrain
  } sum_state_e;

  localparam int unsigned DefaultN = 1024;
  localparam int unsigned DefaultW = 32;

  // a=0, b=all-ones makes the slice reproduce its carry-in as carry-out.
  localparam logic PropBit = 1'b1;

endpackage

// File: rtl/sum_seq_ctrl.sv
// Sequencer for a word-serial carry-chained adder slice.
// Streams an N-bit addition into a W-bit slice as CC = N/W word pairs, LSW first,
// returns CC result words through a single output register and reports the final carry.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, busy, done   operation control / status (done is a one-cycle pulse)
//   cout                final carry-out, valid from done until the next start
//   in_valid/in_ready   operand word pair handshake, in_a / in_b operand words
//   out_valid/out_ready result word handshake, out_data / out_last result word
//   slice_rst           slice carry reset
//   slice_a, slice_b    slice operands; slice_c slice sum (combinational)
module sum_seq_ctrl
  import sum_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         cout,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         slice_rst,
  output logic [W-1:0] slice_a,
  output logic [W-1:0] slice_b,
  input  logic [W-1:0] slice_c
);

  localparam int unsigned CC   = N / W;
  localparam int unsigned CntW = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(CC - 1);

  if ((W == 0) || (N == 0) || ((N % W) != 0)) begin : g_param_check
    $error("sum_seq_ctrl: N must be a non-zero multiple of W");
  end

  sum_state_e    state_q;
  logic [CntW-1:0] count_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic          out_last_q;
  logic          done_q;
  logic          cout_q;
  logic          cout_hold_q;

  logic accept;
  logic out_hs;
  logic word_cout;

  always_comb begin
    in_ready  = !rst && (state_q == StRun) && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    out_hs    = out_valid_q && out_ready;
    slice_rst = rst || (state_q == StClr);
    slice_a   = accept ? in_a : '0;
    slice_b   = accept ? in_b : {W{PropBit}};
    // Carry out of the MSB recovered from the operand and sum MSBs.
    word_cout = (in_a[W-1] & in_b[W-1]) | ((in_a[W-1] ^ in_b[W-1]) & ~slice_c[W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cout_q      <= 1'b0;
      cout_hold_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StClr;
            count_q <= '0;
          end
        end
        StClr: begin
          state_q <= StRun;
        end
        StRun: begin
          if (accept) begin
            count_q <= count_q + CntW'(1);
            if (count_q == LastIdx) begin
              cout_hold_q <= word_cout;
              state_q     <= StDrain;
            end
          end
        end
        StDrain: begin
          // done is raised while still busy, so a start seen alongside it is ignored.
          if (done_q) begin
            state_q <= StIdle;
          end else if (out_hs && out_last_q) begin
            done_q <= 1'b1;
            cout_q <= cout_hold_q;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Single output stage: a new word may replace the old one in its handshake cycle.
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= slice_c;
        out_last_q  <= (count_q == LastIdx);
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Self-checking bench for sum_seq_ctrl with a behavioural slice and an N-bit arithmetic
// reference: expected result words and carry come from a plain (N+1)-bit addition.
module tb_sum_seq_ctrl;

  localparam int unsigned N  = 1024;
  localparam int unsigned W  = 32;
  localparam int unsigned CC = N / W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic         cout;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         slice_rst;
  logic [W-1:0] slice_a;
  logic [W-1:0] slice_b;
  logic [W-1:0] slice_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_seq_ctrl #(
    .N(N),
    .W(W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cout     (cout),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .slice_rst(slice_rst),
    .slice_a  (slice_a),
    .slice_b  (slice_b),
    .slice_c  (slice_c)
  );

  // Behavioural adder slice: free-running carry DFF, cleared only by slice_rst.
  logic         carry_q;
  logic [W:0]   slice_sum;
  assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{W{1'b0}}, carry_q};
  assign slice_c   = slice_sum[W-1:0];
  always_ff @(posedge clk) begin
    if (slice_rst) carry_q <= 1'b0;
    else           carry_q <= slice_sum[W];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // out_mode: 0 always ready, 1 random ready, 2 ready low for 3 valid cycles on word 1.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int in_gap,
                        input bit rnd_in, input int out_mode, input bit poke_start);
    logic [N:0]   ref_sum;
    logic [W-1:0] prev_data;
    bit           prev_stall;
    bit           got_done;
    int           widx, ridx, cyc, gap, hold_cnt, last_hs_cyc, budget;
    ref_sum     = {1'b0, a} + {1'b0, b};
    widx        = 0;
    ridx        = 0;
    cyc         = 0;
    gap         = 0;
    hold_cnt    = 0;
    last_hs_cyc = -10;
    prev_stall  = 1'b0;
    prev_data   = '0;
    got_done    = 1'b0;
    budget      = 2000 + int'(CC) * (in_gap + 1) * 8;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("busy_after_start", busy, 1);

    while (!got_done && cyc < budget) begin
      in_valid = 1'b0;
      if (widx < int'(CC)) begin
        if (gap > 0) gap--;
        else in_valid = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      in_a = (widx < int'(CC)) ? a[widx*W +: W] : W'($urandom());
      in_b = (widx < int'(CC)) ? b[widx*W +: W] : W'($urandom());
      if (!in_valid) begin
        in_a = W'($urandom());
        in_b = W'($urandom());
      end
      case (out_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !(ridx == 1 && hold_cnt < 3);
        default: out_ready = 1'b1;
      endcase
      start = poke_start && (cyc == 4 || cyc == 9);
      #1;

      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready) check_eq("in_ready_blocked", in_ready, 0);

      if (done) begin
        check_eq("done_latency", cyc, last_hs_cyc + 1);
        check_eq("words_returned", ridx, CC);
        check_eq("cout", cout, ref_sum[N]);
        check_eq("busy_at_done", busy, 1);
        got_done = 1'b1;
        start    = 1'b1;  // must be ignored: controller is not yet idle
      end else begin
        check_eq("busy_running", busy, 1);
      end

      if (out_valid && out_ready) begin
        if (ridx < int'(CC)) begin
          check_eq("out_data", out_data, ref_sum[ridx*W +: W]);
          check_eq("out_last", out_last, ridx == int'(CC) - 1);
        end else begin
          check_eq("extra_word", ridx, CC - 1);
        end
        ridx++;
        last_hs_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        widx++;
        gap = in_gap;
      end
      if (out_mode == 2 && ridx == 1 && out_valid && !out_ready) hold_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;

      @(negedge clk);
      cyc++;
    end
    if (!got_done) check_eq("timeout_done", 0, 1);

    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("done_single_pulse", done, 0);
    check_eq("idle_after_done", busy, 0);
    @(negedge clk);
    #1;
    check_eq("start_at_done_ignored", busy, 0);
  endtask

  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] all_ones;
  int           fed;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    all_ones  = '1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_slice_rst", slice_rst, 1);
    rst = 1'b0;

    // Low 64 bits 0x00000000_FFFFFFFF + 1: carry ripples into word 1 only.
    op_a = '0;
    op_a[31:0] = 32'hFFFF_FFFF;
    op_b = '0;
    op_b[0] = 1'b1;
    run_op(op_a, op_b, 0, 1'b0, 0, 1'b0);

    // All-ones + all-ones: FFFFFFFE then FFFFFFFF..., carry out set.
    run_op(all_ones, all_ones, 0, 1'b0, 0, 1'b0);

    // Carry must survive 5 idle input cycles between every word.
    op_b = '0;
    op_b[0] = 1'b1;
    run_op(all_ones, op_b, 5, 1'b0, 0, 1'b0);

    // Output back-pressure on word 1, random operands.
    for (int i = 0; i < int'(CC); i++) begin
      op_a[i*W +: W] = W'($urandom());
      op_b[i*W +: W] = W'($urandom());
    end
    run_op(op_a, op_b, 0, 1'b0, 2, 1'b0);

    // start pulsed mid-run must be ignored.
    run_op(op_b, op_a, 0, 1'b1, 1, 1'b1);

    // Random operands with random stalls on both sides.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < int'(CC); i++) begin
        op_a[i*W +: W] = W'($urandom());
        op_b[i*W +: W] = (t == 3) ? ~op_a[i*W +: W] : W'($urandom());
      end
      run_op(op_a, op_b, t % 2, 1'b1, 1, 1'b0);
    end

    // Carry-generating op, then reset after word 2 while carry is set.
    run_op(all_ones, all_ones, 0, 1'b0, 0, 1'b0);
    op_b = '0;
    op_b[0] = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fed = 0;
    for (int k = 0; k < 200 && fed < 3; k++) begin
      in_valid  = 1'b1;
      in_a      = all_ones[fed*W +: W];
      in_b      = op_b[fed*W +: W];
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) fed++;
      @(negedge clk);
    end
    check_eq("fed_before_rst", fed, 3);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_data", out_data, 0);
    check_eq("midrst_out_last", out_last, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_eq("post_rst_idle", busy, 0);
    end
    run_op('0, '0, 0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sum_seq_ctrl.md
Name: sum_seq_ctrl

Overview:
- Sequencer for the word-serial carry-chained adder slice (W-bit slice, internal carry DFF with no enable, carry cleared only by its reset).
- Streams an N-bit addition as CC = N/W operand word pairs, LSW first, into the slice, and returns CC result words.
- Owns the slice carry lifecycle: clears it at operation start and holds it across input stalls.
- Reports the final carry-out. Sits between the operand source (memory/garbler front end) and the slice.

Parameters:
- N, 1024, total operand width in bits.
- W, 32, slice width in bits. N must be a multiple of W; elaboration error otherwise.
- CC, N/W, words per operation. Derived localparam, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at operation end.
- cout  out  1  final carry-out; valid from the done cycle until the next start.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  operand word pair accepted when in_valid && in_ready.
- in_a  in  W  operand A word.
- in_b  in  W  operand B word.
- out_valid  out  1  result word valid.
- out_ready  in  1  result consumer ready.
- out_data  out  W  result word.
- out_last  out  1  marks result word CC-1.
- slice_rst  out  1  to the slice carry reset.
- slice_a  out  W  to slice operand a.
- slice_b  out  W  to slice operand b.
- slice_c  in  W  from slice sum c (combinational in a, b and carry).

Behaviour:
- Reset values: busy=0, done=0, cout=0, in_ready=0, out_valid=0, out_data=0, out_last=0. State is IDLE and the word counter is 0.
- slice_rst = rst || (state==CLR). This is combinational and guarantees the carry is cleared while rst is asserted.
- FSM states: IDLE, CLR, RUN, DRAIN.
  - IDLE: start=1 -> CLR. Otherwise stay.
  - CLR: one cycle; slice carry cleared at the clock edge. -> RUN.
  - RUN: in_ready = !out_valid || out_ready. On acceptance the counter increments. Accepting word CC-1 -> DRAIN.
  - DRAIN: wait for the handshake on the out_last word. Then done=1 for one cycle, cout registered, -> IDLE.
- Slice drive:
  - On an accepted cycle: slice_a=in_a, slice_b=in_b.
  - In every other cycle: slice_a=0, slice_b=all-ones (propagate pattern). The slice carry DFF then recaptures its own value, so the carry is preserved across stalls and idle cycles.
- Output register: on acceptance, out_data<=slice_c, out_valid<=1, out_last<=(count==CC-1). Latency is one cycle from accept to out_valid.
- Output hold: out_valid/out_data are held stable until out_ready. out_valid clears on handshake unless a new word is accepted in the same cycle. There is no internal FIFO; one register stage only.
- cout: computed at acceptance of word CC-1 as a[W-1]&b[W-1] | (a[W-1]^b[W-1])&~c[W-1]. It is stored and presented at done.
- start: ignored when not in IDLE. start in the same cycle as done is ignored; the controller reaches IDLE the following cycle.
- in_valid outside RUN: not accepted, no effect.
- Counter: width $clog2(CC), minimum 1 bit. Resets to 0 on entry to CLR.
- rst mid-operation: immediate return to IDLE with all outputs at reset values; any partial result is discarded; slice carry cleared.
- CC=1: CLR -> RUN -> DRAIN after a single word; out_last is set on that word.

Decomposition:
- Shared package sum_pkg: FSM state typedef (IDLE/CLR/RUN/DRAIN), default N/W constants, and the propagate-pattern constant.
- No sub-module is needed. The slice is instantiated by the parent, not inside this block.

Test Plan:
- N=64, W=32; A=0x00000000_FFFFFFFF, B=0x00000000_00000001, no stalls -> out words 0x00000000 then 0x00000001 (out_last), cout=0, done 1 cycle after last handshake.
- N=64; A=B=0xFFFFFFFF_FFFFFFFF -> out 0xFFFFFFFE, 0xFFFFFFFF, cout=1.
- Default N=1024; A = all-ones, B = 1 in word 0 only, in_valid low for 5 cycles between every word -> all 32 out words 0x00000000, cout=1. This proves the carry survives stalls.
- out_ready low for 3 cycles after word 0: in_ready low, out_data held at word 0 value, no word lost or duplicated; full result matches the golden model.
- start pulsed during RUN -> ignored; busy stays 1; the result is unaffected.
- rst asserted after word 2 of an op with carry=1, then a new op with A=B=0 -> all outputs 0, cout=0 (carry cleared), busy=0 during and after reset until start.
